// File: rtl/trigger_pkg.sv
// trigger_pkg: shared mode/state types and source constants for trigger_unit_mc
package trigger_pkg;
  typedef enum logic [1:0] {ABOVE, BELOW, INSIDE, OUTSIDE} trig_mode_t;
  typedef enum logic [2:0] {IDLE, ARMING, ARMED, DELAY, GO, HOLDOFF, DONE} trig_state_t;
  localparam int unsigned SRC_EXT = 0;
endpackage

// File: rtl/trigger_compare.sv
// trigger_compare: registered per-channel level/window compare
// TRIG_HYST_EN turns the compare into a set/reset latch with hysteresis hyst.
module trigger_compare
  import trigger_pkg::*;
#(
  parameter int ADC_W = 12
) (
  input  logic             adc_clk,
  input  logic             reset_n,
`ifdef TRIG_HYST_EN
  input  logic             clr,
  input  logic [ADC_W-1:0] hyst,
`endif
  input  logic [ADC_W-1:0] data,
  input  logic [ADC_W-1:0] lvl_hi,
  input  logic [ADC_W-1:0] lvl_lo,
  input  trig_mode_t       mode,
  output logic             hit
);
  logic cond;
  always_comb
    cond = mode == ABOVE  ? data > lvl_hi :
           mode == BELOW  ? data < lvl_lo :
           mode == INSIDE ? (data >= lvl_lo && data <= lvl_hi) :
                            (data < lvl_lo || data > lvl_hi);
`ifdef TRIG_HYST_EN
  function automatic logic [ADC_W-1:0] sub_s(input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] b);
    return a >= b ? a - b : '0;
  endfunction
  function automatic logic [ADC_W-1:0] add_s(input logic [ADC_W-1:0] a, input logic [ADC_W-1:0] b);
    logic [ADC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ADC_W] ? '1 : s[ADC_W-1:0];
  endfunction
  logic [ADC_W-1:0] hi_m, hi_p, lo_m, lo_p;
  logic rel;
  always_comb begin
    hi_m = sub_s(lvl_hi, hyst);
    hi_p = add_s(lvl_hi, hyst);
    lo_m = sub_s(lvl_lo, hyst);
    lo_p = add_s(lvl_lo, hyst);
    rel  = mode == ABOVE  ? data <= hi_m :
           mode == BELOW  ? data >= lo_p :
           mode == INSIDE ? (data <= lo_m || data >= hi_p) :
                            (data >= lo_p && data <= hi_m);
  end
  // in IDLE the latch degenerates to the raw compare so arming still sees a live level
  always_ff @(posedge adc_clk)
    hit <= !reset_n ? 1'b0 : cond || (hit && !rel && !clr);
`else
  always_ff @(posedge adc_clk)
    hit <= !reset_n ? 1'b0 : cond;
`endif
endmodule

// File: rtl/trigger_unit_mc.sv
// trigger_unit_mc: multi-channel, multi-segment trigger FSM issuing capture_go_o per segment
// TRIG_HYST_EN adds hyst_i and hysteresis latches in the channel compares.
module trigger_unit_mc
  import trigger_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int NCH   = 4,
  parameter int CNT_W = 32,
  parameter int SEG_W = 16
) (
  input  logic                 adc_clk,
  input  logic                 reset_n,
  input  logic [NCH*ADC_W-1:0] adc_data,
  input  logic                 ext_trigger_i,
  input  logic [$clog2(NCH):0] src_sel_i,
  input  logic [1:0]           mode_i,
  input  logic [ADC_W-1:0]     lvl_hi_i,
  input  logic [ADC_W-1:0]     lvl_lo_i,
`ifdef TRIG_HYST_EN
  input  logic [ADC_W-1:0]     hyst_i,
`endif
  input  logic                 trigger_level_i,
  input  logic                 trigger_wait_i,
  input  logic                 trigger_now_i,
  input  logic                 arm_i,
  input  logic                 armed_and_ready,
  input  logic [CNT_W-1:0]     trigger_offset_i,
  input  logic [CNT_W-1:0]     holdoff_i,
  input  logic [SEG_W-1:0]     num_segments_i,
  input  logic                 capture_done_i,
  output logic                 arm_o,
  output logic                 capture_active_o,
  output logic                 capture_go_o,
  output logic [SEG_W-1:0]     segment_cnt_o,
  output logic [CNT_W-1:0]     trigger_length_o,
  output logic [2:0]           state_o
);
  localparam int SW = $clog2(NCH) + 1;
  trig_state_t state, nxt, fire_to;
  logic [NCH-1:0] hit;
  logic [(1 << SW)-1:0] hit_x;
  logic [2:0] tsync;
  logic [CNT_W-1:0] cnt;
  logic [SEG_W-1:0] seg_inc, nseg;
  logic arm_d, raw, trigger, tnow, start, abort, fire, first_fire, go, first, last, len_run;
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    trigger_compare #(.ADC_W(ADC_W)) u_cmp (
      .adc_clk (adc_clk),
      .reset_n (reset_n),
`ifdef TRIG_HYST_EN
      .clr     (state == IDLE),
      .hyst    (hyst_i),
`endif
      .data    (adc_data[k*ADC_W +: ADC_W]),
      .lvl_hi  (lvl_hi_i),
      .lvl_lo  (lvl_lo_i),
      .mode    (trig_mode_t'(mode_i)),
      .hit     (hit[k])
    );
  end
  always_comb begin
    hit_x   = {{((1 << SW) - NCH){1'b0}}, hit};
    raw     = (src_sel_i == SW'(SRC_EXT) || src_sel_i > SW'(NCH)) ? ext_trigger_i : hit_x[src_sel_i - SW'(1)];
    trigger = ~(raw ^ trigger_level_i);
    tnow    = tsync[1] & ~tsync[2];
    start   = state == IDLE && arm_i && !arm_d;
    first   = segment_cnt_o == '0;
    seg_inc = &segment_cnt_o ? segment_cnt_o : segment_cnt_o + SEG_W'(1);
    nseg    = num_segments_i == '0 ? SEG_W'(1) : num_segments_i;
    last    = seg_inc >= nseg;
    fire_to = trigger_offset_i == '0 ? GO : DELAY;
    abort   = state != IDLE && state != DONE && (!arm_i || capture_done_i);
    nxt     = IDLE;
    fire    = 1'b0;
    go      = 1'b0;
    if (!abort)
      case (state)
        IDLE:    nxt = start ? ARMING : IDLE;
        ARMING: begin
          fire = tnow;
          // later segments always need the trigger to fall first so each go is a fresh edge
          nxt  = tnow ? fire_to :
                 (armed_and_ready && (!trigger || (!trigger_wait_i && first))) ? ARMED : ARMING;
        end
        ARMED: begin
          fire = trigger || tnow;
          nxt  = fire ? fire_to : ARMED;
        end
        DELAY:   nxt = cnt >= trigger_offset_i ? GO : DELAY;
        GO: begin
          go  = 1'b1;
          nxt = last ? DONE : HOLDOFF;
        end
        HOLDOFF: nxt = cnt >= holdoff_i ? ARMING : HOLDOFF;
        DONE:    nxt = (!arm_i && (!capture_active_o || capture_done_i)) ? IDLE : DONE;
        default: nxt = IDLE;
      endcase
    first_fire = fire && first;
  end
  assign capture_go_o = go;
  assign state_o      = state;
  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      tsync            <= '0;
      arm_d            <= 1'b0;
      cnt              <= '0;
      segment_cnt_o    <= '0;
      arm_o            <= 1'b0;
      capture_active_o <= 1'b0;
      trigger_length_o <= '0;
      len_run          <= 1'b0;
    end else begin
      state            <= nxt;
      tsync            <= {tsync[1:0], trigger_now_i};
      arm_d            <= arm_i;
      // the trigger cycle itself is count 0, so offset N lands go N+1 cycles after it
      cnt              <= (fire || go) ? CNT_W'(1) : &cnt ? cnt : cnt + CNT_W'(1);
      segment_cnt_o    <= start ? '0 : go ? seg_inc : segment_cnt_o;
      arm_o            <= abort ? 1'b0 : start ? 1'b1 : first_fire ? 1'b0 : arm_o;
      capture_active_o <= (abort || (state == DONE && capture_done_i)) ? 1'b0 : fire ? 1'b1 : capture_active_o;
      len_run          <= state == IDLE ? 1'b0 : (first_fire && trigger) || (len_run && trigger);
      trigger_length_o <= start ? '0 :
                          (first_fire && trigger) ? CNT_W'(1) :
                          (len_run && trigger && !(&trigger_length_o)) ? trigger_length_o + CNT_W'(1) :
                          trigger_length_o;
    end
  end
endmodule
